// File: rtl/pump_pkg.sv
// Shared definitions for the MCU data-pump download receiver:
// the command byte values and the frame-decoder FSM state encoding.
package pump_pkg;

  localparam logic [7:0] CMD_START  = 8'h01;
  localparam logic [7:0] CMD_DATA   = 8'h02;
  localparam logic [7:0] CMD_END    = 8'h03;
  localparam logic [7:0] CMD_STATUS = 8'h04;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_CMD    = 4'd1,
    ST_ADDR0  = 4'd2,
    ST_ADDR1  = 4'd3,
    ST_ADDR2  = 4'd4,
    ST_DATA   = 4'd5,
    ST_END    = 4'd6,
    ST_STATUS = 4'd7,
    ST_IGNORE = 4'd8
  } pump_state_t;

endpackage

// File: rtl/pump_download_rx_if.sv
// Byte-write handshake between the download receiver and the ROM/SDRAM loader.
//   wr_req_o  : write request, held until acknowledged (receiver -> loader)
//   wr_ack_i  : loader accepted the current byte     (loader -> receiver)
//   wr_addr_o : byte address of the current write    (receiver -> loader)
//   wr_data_o : byte to write                        (receiver -> loader)
// Modport master is the receiver side, slave is the loader side.
interface pump_download_rx_if #(
  parameter int ADDR_W = 24
);
  logic              wr_req_o;
  logic              wr_ack_i;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [7:0]        wr_data_o;

  modport master (output wr_req_o, output wr_addr_o, output wr_data_o, input wr_ack_i);
  modport slave  (input wr_req_o, input wr_addr_o, input wr_data_o, output wr_ack_i);
endinterface

// File: rtl/pump_spi_byte.sv
// SPI mode-0 slave byte engine: 2-FF synchronisers on sck/ss_n/mosi,
// edge detection on the synchronised sck, MSB-first receive shifter with a
// one-clock byte strobe, and an MSB-first MISO shifter with a parallel load.
// Ports:
//   clk_i, rst_n_i        system clock, async active-low reset
//   sck_i, ss_n_i, mosi_i raw asynchronous SPI inputs
//   load_i, load_data_i   parallel load of the MISO shifter
//   miso_en_i             gates MISO (0 when disabled)
//   byte_stb_o, byte_o    received byte, strobe 1 clk after the 8th rise
//   ss_n_o                synchronised chip select level
//   miso_o                serial data to the MCU
module pump_spi_byte (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       sck_i,
  input  logic       ss_n_i,
  input  logic       mosi_i,
  input  logic       load_i,
  input  logic [7:0] load_data_i,
  input  logic       miso_en_i,
  output logic       byte_stb_o,
  output logic [7:0] byte_o,
  output logic       ss_n_o,
  output logic       miso_o
);
  logic [2:0] r_sck;       // [0] meta, [1] sync, [2] previous sync
  logic [1:0] r_ss_n;
  logic [1:0] r_mosi;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic [7:0] r_byte;
  logic [7:0] r_miso_sh;
  logic       r_byte_stb;
  logic       w_sck_rise;
  logic       w_sck_fall;
  logic       w_ss_n;
  logic       w_mosi;

  assign w_sck_rise = r_sck[1] & ~r_sck[2];
  assign w_sck_fall = ~r_sck[1] & r_sck[2];
  assign w_ss_n     = r_ss_n[1];
  assign w_mosi     = r_mosi[1];

  assign byte_stb_o = r_byte_stb;
  assign byte_o     = r_byte;
  assign ss_n_o     = w_ss_n;
  assign miso_o     = r_miso_sh[7] & miso_en_i;

  // Two-stage synchronisers; ss_n idles high so the FSM stays in IDLE out of reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_sck  <= 3'b000;
      r_ss_n <= 2'b11;
      r_mosi <= 2'b00;
    end else begin
      r_sck  <= {r_sck[1:0], sck_i};
      r_ss_n <= {r_ss_n[0], ss_n_i};
      r_mosi <= {r_mosi[0], mosi_i};
    end
  end

  // Receive shifter; deselect discards any partial byte.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_bit_cnt  <= 3'd0;
      r_shift    <= 8'h00;
      r_byte     <= 8'h00;
      r_byte_stb <= 1'b0;
    end else if (w_ss_n) begin
      r_bit_cnt  <= 3'd0;
      r_byte_stb <= 1'b0;
    end else begin
      r_byte_stb <= w_sck_rise & (r_bit_cnt == 3'd7);
      if (w_sck_rise) begin
        r_shift   <= {r_shift[6:0], w_mosi};
        r_bit_cnt <= r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) begin
          r_byte <= {r_shift[6:0], w_mosi};
        end
      end
    end
  end

  // MISO shifter. The fall after the 8th rise (bit count back at 0) must not
  // shift, otherwise a freshly loaded MSB would be lost before the MCU samples it.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_miso_sh <= 8'h00;
    end else if (load_i) begin
      r_miso_sh <= load_data_i;
    end else if (w_ss_n) begin
      r_miso_sh <= 8'h00;
    end else if (w_sck_fall && (r_bit_cnt != 3'd0)) begin
      r_miso_sh <= {r_miso_sh[6:0], 1'b0};
    end
  end

endmodule

// File: rtl/pump_download_rx.sv
// FPGA-side responder for the MCU data pump. Decodes SPI download frames
// (START/DATA/END/STATUS), turns DATA payload into a req/ack byte-write
// stream, drives the download flag and answers STATUS with the pump code.
// Ports:
//   clk_i, reset_n_i                   clock, async active-low reset
//   spi_sck_i, spi_ss_n_i, spi_mosi_i  SPI from the MCU (asynchronous)
//   spi_miso_o                         SPI to the MCU, 0 outside STATUS
//   pump_i                             pump status code returned by STATUS
//   download_o                         high between START and END
//   wr                                 write handshake (pump_download_rx_if.master)
//   overrun_o                          sticky dropped-byte flag, cleared by START
//   cksum_err_o                        (PUMP_CHECKSUM_EN only) sticky checksum error
// Optional feature: define PUMP_CHECKSUM_EN to keep an XOR checksum of DATA
// bytes, expect a checksum byte after END and report it in STATUS bit 0.
module pump_download_rx
  import pump_pkg::*;
#(
  parameter int ADDR_W = 24
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       spi_sck_i,
  input  logic       spi_ss_n_i,
  input  logic       spi_mosi_i,
  output logic       spi_miso_o,
  input  logic [7:0] pump_i,
  output logic       download_o,
  pump_download_rx_if.master wr,
  output logic       overrun_o
`ifdef PUMP_CHECKSUM_EN
  ,
  output logic       cksum_err_o
`endif
);
  pump_state_t       r_state;
  pump_state_t       w_state_nxt;
  logic [15:0]       r_addr_acc;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [7:0]        r_wr_data;
  logic              r_wr_req;
  logic              r_download;
  logic              r_overrun;
  logic              r_end_pend;
  logic              w_byte_stb;
  logic [7:0]        w_byte;
  logic              w_ss_n;
  logic              w_addr_shift;
  logic              w_start_go;
  logic              w_data_go;
  logic              w_end_go;
  logic              w_status_ld;
  logic              w_miso_en;
  logic [7:0]        w_status_byte;
  logic              w_ack;
`ifdef PUMP_CHECKSUM_EN
  logic [7:0]        r_cksum;
  logic              r_cksum_err;
  logic              w_cksum_chk;
  assign cksum_err_o   = r_cksum_err;
  assign w_status_byte = {pump_i[7:1], r_cksum_err};
`else
  assign w_status_byte = pump_i;
`endif

  assign w_ack        = r_wr_req & wr.wr_ack_i;
  assign download_o   = r_download;
  assign overrun_o    = r_overrun;
  assign wr.wr_req_o  = r_wr_req;
  assign wr.wr_addr_o = r_wr_addr;
  assign wr.wr_data_o = r_wr_data;

  pump_spi_byte u_spi (
    .clk_i       (clk_i),
    .rst_n_i     (reset_n_i),
    .sck_i       (spi_sck_i),
    .ss_n_i      (spi_ss_n_i),
    .mosi_i      (spi_mosi_i),
    .load_i      (w_status_ld),
    .load_data_i (w_status_byte),
    .miso_en_i   (w_miso_en),
    .byte_stb_o  (w_byte_stb),
    .byte_o      (w_byte),
    .ss_n_o      (w_ss_n),
    .miso_o      (spi_miso_o)
  );

  // FSM state register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: deselect always returns to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    if (r_state != ST_IDLE && w_ss_n) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (!w_ss_n) w_state_nxt = ST_CMD; else w_state_nxt = ST_IDLE;
        ST_CMD: begin
          if (w_byte_stb) begin
            case (w_byte)
              CMD_START:  w_state_nxt = ST_ADDR0;
              CMD_DATA:   w_state_nxt = ST_DATA;
              CMD_END:    w_state_nxt = ST_END;
              CMD_STATUS: w_state_nxt = ST_STATUS;
              default:    w_state_nxt = ST_IGNORE;
            endcase
          end else begin
            w_state_nxt = ST_CMD;
          end
        end
        ST_ADDR0: if (w_byte_stb) w_state_nxt = ST_ADDR1; else w_state_nxt = ST_ADDR0;
        ST_ADDR1: if (w_byte_stb) w_state_nxt = ST_ADDR2; else w_state_nxt = ST_ADDR1;
        // Bytes after the third address byte are meaningless; swallow them.
        ST_ADDR2: if (w_byte_stb) w_state_nxt = ST_IGNORE; else w_state_nxt = ST_ADDR2;
`ifdef PUMP_CHECKSUM_EN
        ST_END:   if (w_byte_stb) w_state_nxt = ST_IGNORE; else w_state_nxt = ST_END;
`endif
        default:  w_state_nxt = r_state;
      endcase
    end
  end

  // FSM outputs: one-clock action strobes for the datapath.
  always_comb begin
    w_addr_shift = w_byte_stb & ((r_state == ST_ADDR0) | (r_state == ST_ADDR1));
    w_start_go   = w_byte_stb & (r_state == ST_ADDR2);
    w_data_go    = w_byte_stb & (r_state == ST_DATA) & r_download;
    w_end_go     = w_byte_stb & (r_state == ST_CMD) & (w_byte == CMD_END);
    w_status_ld  = w_byte_stb & (r_state == ST_CMD) & (w_byte == CMD_STATUS);
    w_miso_en    = (r_state == ST_STATUS);
`ifdef PUMP_CHECKSUM_EN
    w_cksum_chk  = w_byte_stb & (r_state == ST_END);
`endif
  end

  // Address collection and write address counter (advances on ack, wraps).
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_addr_acc <= 16'h0000;
      r_wr_addr  <= '0;
    end else begin
      if (w_addr_shift) r_addr_acc <= {r_addr_acc[7:0], w_byte};
      if (w_start_go) begin
        r_wr_addr <= ADDR_W'({r_addr_acc, w_byte});
      end else if (w_ack) begin
        r_wr_addr <= r_wr_addr + ADDR_W'(1'b1);
      end
    end
  end

  // Write handshake: a byte arriving while a request is pending is dropped.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_wr_req  <= 1'b0;
      r_wr_data <= 8'h00;
      r_overrun <= 1'b0;
    end else begin
      if (r_wr_req) begin
        if (wr.wr_ack_i) r_wr_req <= 1'b0;
      end else if (w_data_go) begin
        r_wr_req  <= 1'b1;
        r_wr_data <= w_byte;
      end
      if (w_start_go) begin
        r_overrun <= 1'b0;
      end else if (w_data_go && r_wr_req) begin
        r_overrun <= 1'b1;
      end
    end
  end

  // Download flag; END with an unacknowledged write defers the drop until the ack.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_download <= 1'b0;
      r_end_pend <= 1'b0;
    end else if (w_start_go) begin
      r_download <= 1'b1;
      r_end_pend <= 1'b0;
    end else if (w_end_go) begin
      if (r_wr_req && !wr.wr_ack_i) r_end_pend <= 1'b1;
      else                          r_download <= 1'b0;
    end else if (r_end_pend && w_ack) begin
      r_download <= 1'b0;
      r_end_pend <= 1'b0;
    end
  end

`ifdef PUMP_CHECKSUM_EN
  // Running XOR of DATA bytes and sticky mismatch flag.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_cksum     <= 8'h00;
      r_cksum_err <= 1'b0;
    end else if (w_start_go) begin
      r_cksum     <= 8'h00;
      r_cksum_err <= 1'b0;
    end else begin
      if (w_data_go) r_cksum <= r_cksum ^ w_byte;
      if (w_cksum_chk && (w_byte != r_cksum)) r_cksum_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pump_download_rx.sv
// Self-checking bench for pump_download_rx: table of frame vectors, hand
// sequences for handshake corners, and randomized frames against a
// transaction-level model (address/download/overrun + expected write list).
module tb_pump_download_rx;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       sck, ss_n, mosi, miso;
  logic [7:0] pump;
  logic       download, overrun;
`ifdef PUMP_CHECKSUM_EN
  logic       cksum_err;
`endif

  always #5 clk = ~clk;

  pump_download_rx_if #(.ADDR_W(24)) wr_if ();

  pump_download_rx #(.ADDR_W(24)) dut (
    .clk_i      (clk),
    .reset_n_i  (rst_n),
    .spi_sck_i  (sck),
    .spi_ss_n_i (ss_n),
    .spi_mosi_i (mosi),
    .spi_miso_o (miso),
    .pump_i     (pump),
    .download_o (download),
    .wr         (wr_if),
    .overrun_o  (overrun)
`ifdef PUMP_CHECKSUM_EN
    ,
    .cksum_err_o(cksum_err)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- loader model (acks, records writes) ----------------
  int          ack_delay = 3;
  bit          ack_hold  = 1'b0;
  logic [31:0] got_q[$];

  initial begin
    int cnt;
    cnt = 0;
    wr_if.wr_ack_i = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n || !wr_if.wr_req_o || wr_if.wr_ack_i) begin
        wr_if.wr_ack_i = 1'b0;
        cnt = 0;
      end else if (!ack_hold) begin
        cnt++;
        if (cnt >= ack_delay) begin
          wr_if.wr_ack_i = 1'b1;
          got_q.push_back({wr_if.wr_addr_o, wr_if.wr_data_o});
          cnt = 0;
        end
      end
    end
  end

  // ---------------- reference model ----------------
  logic [23:0] m_addr;
  bit          m_dl;
  bit          m_ovr;
  logic [31:0] exp_q[$];

  task automatic m_reset();
    m_addr = 24'h0; m_dl = 1'b0; m_ovr = 1'b0; exp_q.delete();
  endtask
  task automatic m_start(input logic [23:0] a);
    m_addr = a; m_dl = 1'b1; m_ovr = 1'b0;
  endtask
  // Prompt-ack model: each accepted byte is written and the address steps by one.
  task automatic m_data(input logic [7:0] b);
    if (m_dl) begin
      exp_q.push_back({m_addr, b});
      m_addr = (m_addr + 24'd1) % 25'h1000000;
    end
  endtask

  // ---------------- SPI master ----------------
  task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = tx[i];
      repeat (8) @(negedge clk);
      rx = {rx[6:0], miso};
      sck = 1'b1;
      repeat (8) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  // Send n bytes taken MSB-first from bytes; returns the last byte read on MISO.
  task automatic frame(input int n, input logic [63:0] bytes, output logic [7:0] rx_last);
    logic [7:0] rx;
    rx = 8'h00;
    ss_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < n; i++) spi_xfer(bytes[63-8*i -: 8], 8, rx);
    repeat (4) @(negedge clk);
    ss_n = 1'b1;
    repeat (12) @(negedge clk);
    rx_last = rx;
  endtask

  task automatic end_frame();
    logic [7:0] rx;
`ifdef PUMP_CHECKSUM_EN
    frame(2, {8'h03, 8'h00, 48'h0}, rx);
`else
    frame(1, {8'h03, 56'h0}, rx);
`endif
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (wr_if.wr_req_o === 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      checks++; errors++;
      $display("FAIL wait_idle: got req stuck high, required it to drop within 400 clks");
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_writes(input string name);
    int n;
    chk({name, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({name, "_write"}, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_model(input string name);
    chk({name, "_download"}, download, m_dl);
    chk({name, "_addr"}, wr_if.wr_addr_o, m_addr);
    chk({name, "_overrun"}, overrun, m_ovr);
    chk({name, "_miso"}, miso, 1'b0);
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    int          kind;      // 0 START, 1 STATUS, 2 END, 3 unknown command
    logic [23:0] arg;
    logic [7:0]  pump_val;
    logic        exp_dl;
    logic [23:0] exp_addr;
    logic [7:0]  exp_miso;
  } vec_t;
  vec_t tbl[7];

  initial begin
    logic [7:0] rx;
    logic [63:0] bytes;
    int n, sel;

    tbl[0] = '{0, 24'h123456, 8'h00, 1'b1, 24'h123456, 8'h00};
    tbl[1] = '{1, 24'h000000, 8'h3F, 1'b1, 24'h123456, 8'h3F};
    tbl[2] = '{1, 24'h000000, 8'hA5, 1'b1, 24'h123456, 8'hA5};
    tbl[3] = '{3, 24'h000000, 8'h00, 1'b1, 24'h123456, 8'h00};
    tbl[4] = '{2, 24'h000000, 8'h00, 1'b0, 24'h123456, 8'h00};
    tbl[5] = '{1, 24'h000000, 8'h00, 1'b0, 24'h123456, 8'h00};
    tbl[6] = '{0, 24'hABCDEF, 8'h00, 1'b1, 24'hABCDEF, 8'h00};

    rst_n = 1'b0; sck = 1'b0; ss_n = 1'b1; mosi = 1'b0; pump = 8'h00;
    m_reset();
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset_req", wr_if.wr_req_o, 1'b0);
    chk("reset_data", wr_if.wr_data_o, 8'h00);
    check_model("reset");

    // START 01 12 34 56, then DATA AA BB with ack 3 clks after each req.
    frame(4, {8'h01, 8'h12, 8'h34, 8'h56, 32'h0}, rx);
    m_start(24'h123456);
    check_model("start");
    ack_delay = 3;
    frame(3, {8'h02, 8'hAA, 8'hBB, 40'h0}, rx);
    wait_idle();
    m_data(8'hAA); m_data(8'hBB);
    check_writes("data2");
    check_model("data2");

    // Ack withheld across two DATA bytes: first kept, second dropped.
    ack_hold = 1'b1;
    frame(3, {8'h02, 8'h11, 8'h22, 40'h0}, rx);
    chk("ovr_req", wr_if.wr_req_o, 1'b1);
    chk("ovr_data", wr_if.wr_data_o, 8'h11);
    chk("ovr_addr", wr_if.wr_addr_o, 24'h123458);
    chk("ovr_flag", overrun, 1'b1);
    ack_hold = 1'b0;
    wait_idle();
    m_data(8'h11);
    m_ovr = 1'b1;
    check_writes("ovr");
    check_model("ovr_after");

    // Address wrap, then END.
    frame(4, {8'h01, 8'hFF, 8'hFF, 8'hFF, 32'h0}, rx);
    m_start(24'hFFFFFF);
    check_model("wrap_start");
    frame(3, {8'h02, 8'hC1, 8'hC2, 40'h0}, rx);
    wait_idle();
    m_data(8'hC1); m_data(8'hC2);
    check_writes("wrap");
    end_frame();
    m_dl = 1'b0;
    check_model("wrap_end");

    // END while a write is pending: download drops only after the ack.
    frame(4, {8'h01, 8'h00, 8'h00, 8'h10, 32'h0}, rx);
    m_start(24'h000010);
    ack_hold = 1'b1;
    frame(2, {8'h02, 8'h5A, 48'h0}, rx);
    end_frame();
    chk("endpend_download", download, 1'b1);
    chk("endpend_req", wr_if.wr_req_o, 1'b1);
    ack_hold = 1'b0;
    wait_idle();
    m_data(8'h5A);
    m_dl = 1'b0;
    check_writes("endpend");
    check_model("endpend");

    // Table-driven frames.
    for (int i = 0; i < 7; i++) begin
      rx = 8'h00;
      case (tbl[i].kind)
        0: frame(4, {8'h01, tbl[i].arg, 32'h0}, rx);
        1: begin
          pump = tbl[i].pump_val;
          frame(2, {8'h04, 8'h00, 48'h0}, rx);
          chk($sformatf("tbl%0d_status", i), rx, tbl[i].exp_miso);
        end
        2: end_frame();
        default: frame(3, {8'h77, 8'h02, 8'hAA, 40'h0}, rx);
      endcase
      wait_idle();
      chk($sformatf("tbl%0d_download", i), download, tbl[i].exp_dl);
      chk($sformatf("tbl%0d_addr", i), wr_if.wr_addr_o, tbl[i].exp_addr);
      chk($sformatf("tbl%0d_overrun", i), overrun, 1'b0);
      chk($sformatf("tbl%0d_nowrite", i), got_q.size(), 0);
      got_q.delete();
    end
    m_start(24'hABCDEF);

    // Randomized frames against the model.
    for (int it = 0; it < 16; it++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 5) begin
        ack_delay = $urandom_range(1, 6);
        n = $urandom_range(1, 4);
        bytes = {8'h02, 56'h0};
        for (int k = 1; k <= n; k++) bytes[63-8*k -: 8] = 8'($urandom_range(0, 255));
        frame(n + 1, bytes, rx);
        wait_idle();
        for (int k = 1; k <= n; k++) m_data(bytes[63-8*k -: 8]);
        check_writes($sformatf("rnd%0d", it));
      end else if (sel <= 7) begin
        pump = 8'($urandom_range(0, 255));
        frame(2, {8'h04, 8'h00, 48'h0}, rx);
        chk($sformatf("rnd%0d_status", it), rx, pump);
      end else if (sel == 8) begin
        end_frame();
        m_dl = 1'b0;
      end else begin
        bytes = {8'h01, 24'($urandom), 32'h0};
        frame(4, bytes, rx);
        m_start(bytes[55:32]);
      end
      check_model($sformatf("rnd%0d", it));
    end

    // Partial byte on deselect, then reset in the middle of a pending write.
    ack_delay = 3;
    frame(4, {8'h01, 8'h00, 8'h01, 8'h00, 32'h0}, rx);
    m_start(24'h000100);
    ss_n = 1'b0;
    repeat (4) @(negedge clk);
    spi_xfer(8'h02, 8, rx);
    spi_xfer(8'hF0, 4, rx);
    ss_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("partial_req", wr_if.wr_req_o, 1'b0);
    check_writes("partial");
    check_model("partial");
    ack_hold = 1'b1;
    frame(2, {8'h02, 8'hCC, 48'h0}, rx);
    chk("midwr_req", wr_if.wr_req_o, 1'b1);
    chk("midwr_data", wr_if.wr_data_o, 8'hCC);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req", wr_if.wr_req_o, 1'b0);
    chk("rst_data", wr_if.wr_data_o, 8'h00);
    m_reset();
    check_model("rst");
    ack_hold = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst_after_req", wr_if.wr_req_o, 1'b0);
    check_writes("rst_after");
    check_model("rst_after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got no completion, required finish within 5 ms");
    $fatal(1, "watchdog expired");
  end

endmodule
